// File: rtl/tline_pkg.sv
// Shared types and Q1.15 helpers for the transmission-line far-end model.
// Saturation is width-generic so one helper serves every sample width.
package tline_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int Q15_ONE = 32768;
   localparam int Q15_RND = 16384;

   // Clamp x to the signed range of a w-bit word; caller truncates to w bits.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end
      if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/tline_delay_ram.sv
// Circular sample buffer: combinational read, write on the clock edge, so a
// read and a write in the same beat see the old contents. No reset on storage.
module tline_delay_ram #(
   parameter int W     = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/tline_far_end.sv
// Load end of a lossy line: DELAY-sample delay, Q1.15 attenuation, split into reflected wave and load voltage.
// One output beat per accepted sample, latency 1; in_ready drops only while a held output beat is not drained.
module tline_far_end
   import tline_pkg::*;
#(
   parameter int W     = 16,
   parameter int DELAY = 8,
   parameter int DEPTH = 16,
   parameter int ALPHA = 32767,
   parameter int GAMMA = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_refl,
   output logic [W-1:0] out_load,
   output logic         filled
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = W + 17;
   localparam logic signed [PW-1:0] ALPHA_Q = PW'(ALPHA);
   localparam logic signed [PW-1:0] GAMMA_Q = PW'(GAMMA);
   localparam logic signed [PW-1:0] RND_Q   = PW'(Q15_RND);

   if (DELAY < 1 || DELAY >= DEPTH) begin : g_bad_delay
      $error("tline_far_end: DELAY must satisfy 1 <= DELAY < DEPTH");
   end

   state_t               state;
   state_t               state_nxt;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        fill_cnt;
   logic                 accept;
   logic [W-1:0]         ram_q;
   logic signed [W-1:0]  delayed;
   logic signed [W-1:0]  att;
   logic signed [W-1:0]  refl;
   logic signed [W-1:0]  load;
   logic signed [PW-1:0] att_p;
   logic signed [PW-1:0] refl_p;

   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign rd_ptr   = wr_ptr - AW'(DELAY);
   assign filled   = (state == RUN);

   tline_delay_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Until DELAY samples are in, buffer slots are stale: the line is at rest.
   always_comb begin
      state_nxt = state;
      delayed   = '0;
      case (state)
         FILL: if (accept && fill_cnt == AW'(DELAY - 1)) state_nxt = RUN;
         RUN:  delayed = ram_q;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      att_p  = PW'(delayed) * ALPHA_Q;
      att    = W'(sat_w(64'((att_p + RND_Q) >>> 15), W));
      refl_p = PW'(att) * GAMMA_Q;
      refl   = W'(sat_w(64'((refl_p + RND_Q) >>> 15), W));
      load   = W'(sat_w(64'(att) + 64'(refl), W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         out_refl  <= '0;
         out_load  <= '0;
      end else if (accept) begin
         wr_ptr    <= wr_ptr + AW'(1);
         if (fill_cnt != AW'(DELAY)) begin
            fill_cnt <= fill_cnt + AW'(1);
         end
         out_valid <= 1'b1;
         out_refl  <= refl;
         out_load  <= load;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
